stage_sequencer: RTL and testbench

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

---
 rtl/stage_pkg.sv | 28 ++
 rtl/stage_intro_timer.sv | 39 +++
 rtl/stage_sequencer.sv | 137 +++++++++++++
 tb/tb_stage_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/stage_pkg.sv
// stage_pkg: shared types and constants for the stage sequencer.
//   state_t        sequencer FSM states
//   MAX_STAGES     largest supported stage count
//   STAGE_TARGET   monsters to destroy per stage
//   stage_target() lookup helper for STAGE_TARGET
package stage_pkg;

   localparam int unsigned MAX_STAGES  = 4;
   localparam int unsigned STAGE_W     = 2;
   localparam int unsigned MONSTER_W   = 6;
   localparam int unsigned INTRO_CNT_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_INTRO    = 3'd1,
      ST_PLAY     = 3'd2,
      ST_CLEARED  = 3'd3,
      ST_FINISHED = 3'd4
   } state_t;

   localparam logic [MONSTER_W-1:0] STAGE_TARGET [MAX_STAGES] =
      '{6'd16, 6'd24, 6'd32, 6'd40};

   function automatic logic [MONSTER_W-1:0] stage_target(input logic [STAGE_W-1:0] s);
      return STAGE_TARGET[s];
   endfunction

endpackage

// File: rtl/stage_intro_timer.sv
// stage_intro_timer: counts down the "stage N" intro in video frames.
//   clk     system clock
//   resetN  synchronous active-low reset (counter -> 0)
//   load    reload the counter with INTRO_FRAMES
//   tick    one frame elapsed (startOfFrame while the intro is shown)
//   hold    freeze the countdown (pause)
//   done    strobe: the last intro frame has elapsed this cycle
module stage_intro_timer
   import stage_pkg::*;
#(
   parameter int unsigned INTRO_FRAMES = 120
) (
   input  logic clk,
   input  logic resetN,
   input  logic load,
   input  logic tick,
   input  logic hold,
   output logic done
);

   localparam logic [INTRO_CNT_W-1:0] LOAD_VAL = INTRO_CNT_W'(INTRO_FRAMES);

   logic [INTRO_CNT_W-1:0] count;

   // The frame seen at count == 1 ends the intro instead of decrementing.
   assign done = tick && !hold && (count == INTRO_CNT_W'(1));

   // Countdown register.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         count <= '0;
      end else if (load) begin
         count <= LOAD_VAL;
      end else if (tick && !hold && (count > INTRO_CNT_W'(1))) begin
         count <= count - INTRO_CNT_W'(1);
      end
   end

endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: game stage flow IDLE -> INTRO -> PLAY -> CLEARED -> ... -> FINISHED.
//   clk, resetN         clock, synchronous active-low reset
//   start_game          level, starts/restarts a game from IDLE or FINISHED
//   startOfFrame        one pulse per video frame, paces the intro
//   pause               level, freezes INTRO and PLAY
//   monster_hit         pulse per destroyed monster
//   player_destroyed    player lost, ends the game
//   stage_num           current stage index (0-based)
//   last_stage          stage_num is the final stage (decoded)
//   win_stage           one-cycle pulse when a stage is cleared
//   intro_active        intro being displayed
//   monsters_left       monsters remaining in the current stage
//   game_finished       game over / all stages done
module stage_sequencer
   import stage_pkg::*;
#(
   parameter int unsigned INTRO_FRAMES = 120,
   parameter int unsigned NUM_STAGES   = 4
) (
   input  logic                 clk,
   input  logic                 resetN,
   input  logic                 start_game,
   input  logic                 startOfFrame,
   input  logic                 pause,
   input  logic                 monster_hit,
   input  logic                 player_destroyed,
   output logic [STAGE_W-1:0]   stage_num,
   output logic                 last_stage,
   output logic                 win_stage,
   output logic                 intro_active,
   output logic [MONSTER_W-1:0] monsters_left,
   output logic                 game_finished
);

   localparam logic [STAGE_W-1:0] LAST_IDX = STAGE_W'(NUM_STAGES - 1);

   state_t                 state, state_nxt;
   logic [STAGE_W-1:0]     stage_nxt;
   logic [MONSTER_W-1:0]   left_nxt;
   logic                   win_nxt, intro_nxt, fin_nxt;
   logic                   intro_load, intro_tick, intro_done;

   assign last_stage = (stage_num == LAST_IDX);

   stage_intro_timer #(
      .INTRO_FRAMES(INTRO_FRAMES)
   ) u_intro_timer (
      .clk    (clk),
      .resetN (resetN),
      .load   (intro_load),
      .tick   (intro_tick),
      .hold   (pause),
      .done   (intro_done)
   );

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         state         <= ST_IDLE;
         stage_num     <= '0;
         monsters_left <= stage_target('0);
         win_stage     <= 1'b0;
         intro_active  <= 1'b0;
         game_finished <= 1'b0;
      end else begin
         state         <= state_nxt;
         stage_num     <= stage_nxt;
         monsters_left <= left_nxt;
         win_stage     <= win_nxt;
         intro_active  <= intro_nxt;
         game_finished <= fin_nxt;
      end
   end

   // Next state plus stage/monster bookkeeping.
   always_comb begin
      state_nxt = state;
      stage_nxt = stage_num;
      left_nxt  = monsters_left;
      case (state)
         ST_IDLE: begin
            stage_nxt = '0;
            left_nxt  = stage_target('0);
            if (start_game) state_nxt = ST_INTRO;
         end
         ST_INTRO: begin
            if (intro_done) state_nxt = ST_PLAY;
         end
         ST_PLAY: begin
            // Losing the player wins over a simultaneous final hit.
            if (!pause) begin
               if (player_destroyed) begin
                  state_nxt = ST_FINISHED;
               end else if (monster_hit && (monsters_left != '0)) begin
                  left_nxt = monsters_left - MONSTER_W'(1);
                  if (monsters_left == MONSTER_W'(1)) state_nxt = ST_CLEARED;
               end
            end
         end
         ST_CLEARED: begin
            // Single cycle regardless of pause.
            if (last_stage) begin
               state_nxt = ST_FINISHED;
            end else begin
               state_nxt = ST_INTRO;
               stage_nxt = stage_num + STAGE_W'(1);
               left_nxt  = stage_target(stage_num + STAGE_W'(1));
            end
         end
         ST_FINISHED: begin
            if (start_game) begin
               state_nxt = ST_INTRO;
               stage_nxt = '0;
               left_nxt  = stage_target('0);
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Status outputs follow the next state; intro timer control.
   always_comb begin
      win_nxt    = 1'b0;
      intro_nxt  = 1'b0;
      fin_nxt    = 1'b0;
      intro_load = 1'b0;
      intro_tick = 1'b0;
      win_nxt    = (state_nxt == ST_CLEARED);
      intro_nxt  = (state_nxt == ST_INTRO);
      fin_nxt    = (state_nxt == ST_FINISHED);
      intro_load = (state_nxt == ST_INTRO) && (state != ST_INTRO);
      intro_tick = startOfFrame && (state == ST_INTRO);
   end

endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: scoreboard bench for stage_sequencer (INTRO_FRAMES = 3).
module tb_stage_sequencer;

   localparam int unsigned INTRO_FRAMES = 3;
   localparam int unsigned NUM_STAGES   = 4;

   logic       clk = 1'b0;
   logic       resetN, start_game, startOfFrame, pause, monster_hit, player_destroyed;
   logic [1:0] stage_num;
   logic       last_stage, win_stage, intro_active, game_finished;
   logic [5:0] monsters_left;

   int checks     = 0;
   int failures   = 0;
   int win_count  = 0;
   int model_left = 0;
   int exp_left_q[$];
   int exp_win_q[$];

   stage_sequencer #(
      .INTRO_FRAMES(INTRO_FRAMES),
      .NUM_STAGES  (NUM_STAGES)
   ) dut (
      .clk              (clk),
      .resetN           (resetN),
      .start_game       (start_game),
      .startOfFrame     (startOfFrame),
      .pause            (pause),
      .monster_hit      (monster_hit),
      .player_destroyed (player_destroyed),
      .stage_num        (stage_num),
      .last_stage       (last_stage),
      .win_stage        (win_stage),
      .intro_active     (intro_active),
      .monsters_left    (monsters_left),
      .game_finished    (game_finished)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int tgt(input int s);
      return 16 + 8 * s;
   endfunction

   task automatic step();
      @(negedge clk);
   endtask

   // Every win_stage pulse must match a queued expected stage.
   always @(negedge clk) begin
      if (resetN === 1'b1 && win_stage === 1'b1) begin
         win_count++;
         if (exp_win_q.size() == 0)
            check("win_unexpected", int'(win_stage), 0);
         else
            check("win_stage_num", int'(stage_num), exp_win_q.pop_front());
      end
   end

   task automatic sof();
      startOfFrame = 1'b1;
      step();
      startOfFrame = 1'b0;
   endtask

   task automatic hit();
      int e;
      e = pause ? model_left : ((model_left == 0) ? 0 : model_left - 1);
      exp_left_q.push_back(e);
      model_left   = e;
      monster_hit  = 1'b1;
      step();
      monster_hit  = 1'b0;
      check("monsters_left", int'(monsters_left), exp_left_q.pop_front());
   endtask

   task automatic start();
      start_game = 1'b1;
      step();
      start_game = 1'b0;
      check("start_intro", int'(intro_active), 1);
      check("start_stage", int'(stage_num), 0);
      check("start_left", int'(monsters_left), 16);
      check("start_fin", int'(game_finished), 0);
      check("start_cnt", int'(dut.u_intro_timer.count), INTRO_FRAMES);
   endtask

   task automatic run_intro(input int s);
      for (int i = 0; i < int'(INTRO_FRAMES); i++) begin
         check("intro_active", int'(intro_active), 1);
         sof();
      end
      check("intro_over", int'(intro_active), 0);
      check("play_left", int'(monsters_left), tgt(s));
      model_left = tgt(s);
   endtask

   task automatic clear_stage(input int s, input bit pause_at_clear);
      check("stage_num", int'(stage_num), s);
      check("last_stage", int'(last_stage), (s == int'(NUM_STAGES) - 1) ? 1 : 0);
      model_left = tgt(s);
      while (model_left > 0) begin
         if (model_left == 1) exp_win_q.push_back(s);
         hit();
      end
      check("cleared_win", int'(win_stage), 1);
      pause = pause_at_clear;
      step();
      pause = 1'b0;
      check("win_pulse_len", int'(win_stage), 0);
      if (s < int'(NUM_STAGES) - 1) begin
         check("next_stage", int'(stage_num), s + 1);
         check("next_left", int'(monsters_left), tgt(s + 1));
         check("next_intro", int'(intro_active), 1);
         check("next_cnt", int'(dut.u_intro_timer.count), INTRO_FRAMES);
      end else begin
         check("finished", int'(game_finished), 1);
         check("final_stage", int'(stage_num), s);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      resetN = 1'b0; start_game = 1'b0; startOfFrame = 1'b0;
      pause = 1'b0; monster_hit = 1'b0; player_destroyed = 1'b0;
      repeat (2) step();
      check("rst_stage", int'(stage_num), 0);
      check("rst_left", int'(monsters_left), 16);
      check("rst_win", int'(win_stage), 0);
      check("rst_intro", int'(intro_active), 0);
      check("rst_fin", int'(game_finished), 0);
      check("rst_cnt", int'(dut.u_intro_timer.count), 0);
      resetN = 1'b1;
      step();
      check("idle_intro", int'(intro_active), 0);

      // Game 1: pause in intro and play, then clear every stage.
      start();
      pause = 1'b1;
      sof(); sof();
      check("pause_intro_cnt", int'(dut.u_intro_timer.count), INTRO_FRAMES);
      check("pause_intro_act", int'(intro_active), 1);
      pause = 1'b0;
      run_intro(0);
      pause = 1'b1;
      repeat (3) hit();
      pause = 1'b0;
      clear_stage(0, 1'b0);
      run_intro(1);
      clear_stage(1, 1'b1);
      run_intro(2);
      clear_stage(2, 1'b0);
      run_intro(3);
      clear_stage(3, 1'b0);
      step();
      check("win_count_game1", win_count, 4);

      // FINISHED holds everything.
      monster_hit = 1'b1; startOfFrame = 1'b1;
      repeat (2) step();
      monster_hit = 1'b0; startOfFrame = 1'b0;
      check("hold_fin", int'(game_finished), 1);
      check("hold_stage", int'(stage_num), 3);
      check("hold_left", int'(monsters_left), 0);

      // Game 2: player loss on the same cycle as the final hit.
      start();
      run_intro(0);
      repeat (15) hit();
      check("left_one", int'(monsters_left), 1);
      monster_hit = 1'b1; player_destroyed = 1'b1;
      step();
      monster_hit = 1'b0; player_destroyed = 1'b0;
      check("loss_fin", int'(game_finished), 1);
      check("loss_left", int'(monsters_left), 1);
      check("loss_win", int'(win_stage), 0);
      step();
      check("win_count_loss", win_count, 4);

      // Game 3: reset in the middle of stage 2.
      start();
      run_intro(0);
      clear_stage(0, 1'b0);
      run_intro(1);
      clear_stage(1, 1'b0);
      run_intro(2);
      repeat (5) hit();
      resetN = 1'b0;
      step();
      resetN = 1'b1;
      check("mid_rst_stage", int'(stage_num), 0);
      check("mid_rst_left", int'(monsters_left), 16);
      check("mid_rst_win", int'(win_stage), 0);
      check("mid_rst_intro", int'(intro_active), 0);
      check("mid_rst_fin", int'(game_finished), 0);
      check("mid_rst_cnt", int'(dut.u_intro_timer.count), 0);
      step();
      check("win_count_total", win_count, 6);
      check("win_q_drain", exp_win_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
